// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / 32/32 divide unit with
// architectural HI/LO registers. One operation occupies the unit for
// 34 cycles: accept, 32 iteration steps, then a sign-fixup/write cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        is_div, neg_res, neg_rem, div_zero;
  logic [31:0] a_raw, opnd, acc_hi, acc_lo;

  logic        is_mul_op, is_div_op, signed_op, accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, add_in, shifted;
  logic        sub_ok;
  logic [31:0] rem_sub;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix, hi_fix, lo_fix;

  // Decode the request and form operand magnitudes for signed ops.
  always_comb begin
    is_mul_op = (func == 6'h18) || (func == 6'h19);
    is_div_op = (func == 6'h1A) || (func == 6'h1B);
    signed_op = (func == 6'h18) || (func == 6'h1A);
    accept    = start && (state == IDLE) && (is_mul_op || is_div_op);
    a_neg     = signed_op && op_a[31];
    b_neg     = signed_op && op_b[31];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
  end

  // One iteration step: shift-add multiply or restoring divide.
  // Both share acc_hi/acc_lo: product halves, or remainder/quotient-shift.
  always_comb begin
    add_in   = acc_lo[0] ? {1'b0, opnd} : '0;
    mul_sum  = {1'b0, acc_hi} + add_in;
    shifted  = {acc_hi, acc_lo[31]};
    sub_ok   = shifted >= {1'b0, opnd};
    // Remainder after a successful subtract is below the divisor, so a
    // 32-bit difference is exact.
    rem_sub  = shifted[31:0] - opnd;
    step_hi  = '0;
    step_lo  = '0;
    if (is_div) begin
      step_hi = sub_ok ? rem_sub : shifted[31:0];
      step_lo = {acc_lo[30:0], sub_ok};
    end else begin
      {step_hi, step_lo} = {mul_sum, acc_lo[31:1]};
    end
  end

  // Sign correction and divide-by-zero override for the final write.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    q_fix    = neg_res ? -acc_lo : acc_lo;
    r_fix    = neg_rem ? -acc_hi : acc_hi;
    if (div_zero) begin
      hi_fix = a_raw;
      lo_fix = '1;
    end else if (is_div) begin
      hi_fix = r_fix;
      lo_fix = q_fix;
    end else begin
      hi_fix = prod_fix[63:32];
      lo_fix = prod_fix[31:0];
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy  = (state != IDLE);
    stall = start && busy;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath, counter and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            is_div   <= is_div_op;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg && is_div_op;
            div_zero <= is_div_op && (op_b == '0);
            a_raw    <= op_a;
            opnd     <= is_div_op ? b_mag : a_mag;
            acc_hi   <= '0;
            acc_lo   <= is_div_op ? a_mag : b_mag;
          end else if (start && func == 6'h11) begin
            hi <= op_a;
          end else if (start && func == 6'h13) begin
            lo <= op_a;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
        end
        FIX: begin
          hi   <= hi_fix;
          lo   <= lo_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with a latency
// countdown, a per-cycle compare process, and directed literal checks.
module tb_mult_div_unit;

  logic        clk, rst_n, start;
  logic [5:0]  func;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func),
    .op_a(op_a), .op_b(op_b), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    res = '0;
    case (f)
      6'h18: res = sa * sb;
      6'h19: res = ua * ub;
      6'h1A: if (b == 0) res = {a, 32'hFFFFFFFF};
             else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      6'h1B: if (b == 0) res = {a, 32'hFFFFFFFF};
             else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: a pending result released after a 33-cycle countdown.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cnt;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0; m_cnt <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        if (m_cnt == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
        m_cnt <= m_cnt - 1;
      end else if (start) begin
        if (func inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
          {p_hi, p_lo} <= ref_op(func, op_a, op_b);
          m_cnt <= 33;
        end else if (func == 6'h11) m_hi <= op_a;
        else if (func == 6'h13)     m_lo <= op_a;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",  {63'b0, busy},  {63'b0, m_cnt > 0});
      check("done",  {63'b0, done},  {63'b0, m_done});
      check("stall", {63'b0, stall}, {63'b0, start && (m_cnt > 0)});
      check("hi",    {32'b0, hi},    {32'b0, m_hi});
      check("lo",    {32'b0, lo},    {32'b0, m_lo});
      check("done_and_busy", {63'b0, done && busy}, 64'd0);
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          k;
    logic [31:0] h0, l0;
    logic        held;
    k = 0; h0 = hi; l0 = lo; held = 1'b1;
    while (k < 40) begin
      @(posedge clk); k++; #3;
      if (done) break;
      if (hi !== h0 || lo !== l0) held = 1'b0;
    end
    check({name, "_lat"},  k, exp_lat);
    check({name, "_hold"}, {63'b0, held}, 64'd1);
    check({name, "_hi"},   {32'b0, hi}, {32'b0, exp_hi});
    check({name, "_lo"},   {32'b0, lo}, {32'b0, exp_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    rst_n = 1'b1; start = 1'b0; func = '0; op_a = '0; op_b = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_hi",   {32'b0, hi}, 64'd0);
    check("rst_lo",   {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", 33, 32'hFFFFFFFE, 32'h00000001);
    issue(6'h18, 32'd17, 32'hFFFF0001);
    wait_done("mult_neg", 33, 32'hFFFFFFFF, 32'hFFEF0011);
    issue(6'h1A, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 33, 32'h00000000, 32'h80000000);
    issue(6'h1B, 32'd5, 32'd0);
    wait_done("divu_z", 33, 32'd5, 32'hFFFFFFFF);
    issue(6'h1A, 32'hFFFFFFFB, 32'd0);
    wait_done("div_z", 33, 32'hFFFFFFFB, 32'hFFFFFFFF);
    issue(6'h1B, 32'd100, 32'd7);
    wait_done("divu_100_7", 33, 32'd2, 32'd14);
    issue(6'h1A, 32'd7, 32'hFFFFFFFE);
    wait_done("div_7_m2", 33, 32'd1, 32'hFFFFFFFD);
    issue(6'h18, 32'hFFFFFFFD, 32'hFFFFFFFB);
    wait_done("mult_m3_m5", 33, 32'd0, 32'd15);

    // Unrecognised func: no effect.
    issue(6'h20, 32'hAAAA5555, 32'd3);
    #1;
    check("ignored_busy", {63'b0, busy}, 64'd0);
    check("ignored_hi",   {32'b0, hi}, 64'd0);

    // MTHI while idle.
    issue(6'h11, 32'h1234, 32'd0);
    check("mthi_hi", {32'b0, hi}, 64'h1234);
    check("mthi_lo", {32'b0, lo}, 64'd15);

    // MTLO presented while a MULTU runs: stalled, LO untouched.
    issue(6'h19, 32'h00010000, 32'h00010000);
    start = 1'b1; func = 6'h13; op_a = 32'hDEAD; op_b = '0;
    #1 check("stall_e1", {63'b0, stall}, 64'd1);
    repeat (5) begin
      @(posedge clk); #3;
      check("stall_lo", {32'b0, lo}, 64'd15);
    end
    start = 1'b0;
    wait_done("multu_stall", 28, 32'd1, 32'd0);
    issue(6'h13, 32'hDEAD, 32'd0);
    check("mtlo_lo", {32'b0, lo}, 64'hDEAD);
    check("mtlo_hi", {32'b0, hi}, 64'd1);

    // Asynchronous reset mid-operation.
    issue(6'h19, 32'h1234, 32'd5);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_hi",   {32'b0, hi}, 64'd0);
    check("midrst_lo",   {32'b0, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #3;
      if (done) seen_done++;
    end
    check("no_done_after_rst", seen_done, 0);
    issue(6'h19, 32'd3, 32'd4);
    wait_done("multu_3_4", 33, 32'd0, 32'd12);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
